fofir_scatter5: RTL and testbench

- 1-to-5 distributor for the FoFIR PE datapath: the write-side counterpart of the 5-input operand selector.
- Accepts one valid/ready stream of words, each tagged with a 3-bit destination, and steers each word into one of five per-lane FIFOs.
- Each lane drains independently over its own valid/ready port.
- Illegal destinations are consumed, counted and flagged.

---
 rtl/fofir_scatter5_if.sv | 36 +++
 rtl/fofir_scatter5.sv | 142 ++++++++++++++
 tb/tb_fofir_scatter5.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fofir_scatter5_if.sv
// fofir_scatter5_if: producer-side stream, five lane drain ports and status
// for the FoFIR 1-to-5 lane distributor.
interface fofir_scatter5_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] in_data;
    logic [2:0]            in_sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data0;
    logic [DATA_WIDTH-1:0] out_data1;
    logic [DATA_WIDTH-1:0] out_data2;
    logic [DATA_WIDTH-1:0] out_data3;
    logic [DATA_WIDTH-1:0] out_data4;
    logic [4:0]            out_valid;
    logic [4:0]            out_ready;
    logic                  err_sel;
    logic [CNT_WIDTH-1:0]  drop_cnt;
    logic                  busy;

    // Producer and lane consumers (testbench or surrounding PE logic).
    modport master (
        output flush, in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
        input  out_valid, err_sel, drop_cnt, busy
    );

    // The distributor itself.
    modport slave (
        input  flush, in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_data4,
        output out_valid, err_sel, drop_cnt, busy
    );
endinterface

// File: rtl/fofir_scatter5.sv
// fofir_scatter5: steers one tagged valid/ready stream into five per-lane
// FIFOs, each drained over its own valid/ready port. Each lane keeps a
// registered copy of its head word so out_data never sees in_data
// combinationally. Destinations 5..7 are swallowed, flagged and counted.
module fofir_scatter5 #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_DEPTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input logic             clk,
    input logic             rst_n,
    fofir_scatter5_if.slave bus
);
    localparam int NL = 5;
    localparam int PW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
    localparam int OW = $clog2(LANE_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q  [NL][LANE_DEPTH];
    logic [DATA_WIDTH-1:0] head_q [NL];
    logic [DATA_WIDTH-1:0] head_d [NL];
    logic [PW-1:0]         wr_ptr_q [NL];
    logic [PW-1:0]         wr_ptr_d [NL];
    logic [PW-1:0]         rd_ptr_q [NL];
    logic [PW-1:0]         rd_ptr_d [NL];
    logic [OW-1:0]         occ_q [NL];
    logic [OW-1:0]         occ_d [NL];

    logic [NL-1:0]         lane_full;
    logic [NL-1:0]         lane_nempty;
    logic [NL-1:0]         nempty_d;
    logic [NL-1:0]         push_w;
    logic [NL-1:0]         pop_w;
    logic [7:0]            ready_by_sel;
    logic                  in_ready_w;
    logic                  accept_w;
    logic                  drop_w;

    logic                  err_sel_q;
    logic [CNT_WIDTH-1:0]  drop_cnt_q;
    logic                  busy_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(LANE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Lane status, acceptance and per-lane push/pop strobes.
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            lane_full[k]   = (occ_q[k] == OW'(LANE_DEPTH));
            lane_nempty[k] = (occ_q[k] != '0);
        end
        // Illegal destinations are always accepted so they can be dropped.
        ready_by_sel = {3'b111, ~lane_full};
        in_ready_w   = !bus.flush && ready_by_sel[bus.in_sel];
        accept_w     = bus.in_valid && in_ready_w;
        drop_w       = accept_w && (bus.in_sel > 3'd4);
        for (int k = 0; k < NL; k++) begin
            push_w[k] = accept_w && (bus.in_sel == 3'(k));
            pop_w[k]  = lane_nempty[k] && bus.out_ready[k] && !bus.flush;
        end
    end

    // Next pointers, occupancy and head register for every lane.
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            wr_ptr_d[k] = wr_ptr_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            occ_d[k]    = occ_q[k];
            head_d[k]   = head_q[k];
            if (bus.flush) begin
                wr_ptr_d[k] = '0;
                rd_ptr_d[k] = '0;
                occ_d[k]    = '0;
            end else begin
                if (push_w[k]) wr_ptr_d[k] = ptr_inc(wr_ptr_q[k]);
                if (pop_w[k])  rd_ptr_d[k] = ptr_inc(rd_ptr_q[k]);
                case ({push_w[k], pop_w[k]})
                    2'b10:   occ_d[k] = occ_q[k] + OW'(1);
                    2'b01:   occ_d[k] = occ_q[k] - OW'(1);
                    default: occ_d[k] = occ_q[k];
                endcase
                // New word becomes head when the lane is, or is about to be, empty.
                if (push_w[k] && ((occ_q[k] == '0) || (pop_w[k] && (occ_q[k] == OW'(1)))))
                    head_d[k] = bus.in_data;
                else if (pop_w[k] && (occ_q[k] > OW'(1)))
                    head_d[k] = mem_q[k][ptr_inc(rd_ptr_q[k])];
            end
            nempty_d[k] = (occ_d[k] != '0);
        end
    end

    // Lane storage; contents are meaningless until covered by occupancy.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (push_w[k]) mem_q[k][wr_ptr_q[k]] <= bus.in_data;
        end
    end

    // Lane pointers, occupancy and head words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NL; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
                head_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NL; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                occ_q[k]    <= occ_d[k];
                head_q[k]   <= head_d[k];
            end
        end
    end

    // Drop flag, saturating drop counter (survives flush) and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            err_sel_q <= drop_w;
            if (drop_w && (drop_cnt_q != {CNT_WIDTH{1'b1}}))
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            busy_q <= |nempty_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = lane_nempty;
    assign bus.out_data0 = head_q[0];
    assign bus.out_data1 = head_q[1];
    assign bus.out_data2 = head_q[2];
    assign bus.out_data3 = head_q[3];
    assign bus.out_data4 = head_q[4];
    assign bus.err_sel   = err_sel_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fofir_scatter5.sv
// tb_fofir_scatter5: directed stimulus for the 1-to-5 distributor with a
// queue-based reference model; a monitor compares every lane output,
// in_ready and the drop status against the model once per cycle.
module tb_fofir_scatter5;
    localparam int DW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = 8;

    logic clk;
    logic rst_n;

    fofir_scatter5_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fofir_scatter5 #(.DATA_WIDTH(DW), .LANE_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q [5][$];
    int            exp_drop = 0;
    logic          exp_err  = 1'b0;

    logic [DW-1:0] od [5];
    assign od[0] = bus.out_data0;
    assign od[1] = bus.out_data1;
    assign od[2] = bus.out_data2;
    assign od[3] = bus.out_data3;
    assign od[4] = bus.out_data4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard: compare just before each rising edge, then
    // advance the model with what the edge does.
    initial begin
        logic       m_flush;
        logic       m_valid;
        logic [2:0] m_sel;
        logic [DW-1:0] m_data;
        logic       rdy_exp;
        bit         any;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                for (int k = 0; k < 5; k++) exp_q[k].delete();
                exp_drop = 0;
                exp_err  = 1'b0;
                continue;
            end
            m_flush = bus.flush;
            m_valid = bus.in_valid;
            m_sel   = bus.in_sel;
            m_data  = bus.in_data;
            if (m_flush)          rdy_exp = 1'b0;
            else if (m_sel > 3'd4) rdy_exp = 1'b1;
            else                  rdy_exp = (exp_q[m_sel].size() < DEPTH);
            check("mon_in_ready", {31'd0, bus.in_ready}, {31'd0, rdy_exp});
            check("mon_err_sel", {31'd0, bus.err_sel}, {31'd0, exp_err});
            check("mon_drop_cnt", {24'd0, bus.drop_cnt}, exp_drop);
            any = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (exp_q[k].size() != 0) any = 1'b1;
                check($sformatf("mon_valid%0d", k), {31'd0, bus.out_valid[k]},
                      {31'd0, (exp_q[k].size() != 0)});
                if (bus.out_valid[k] && exp_q[k].size() != 0) begin
                    check($sformatf("mon_data%0d", k), {16'd0, od[k]}, {16'd0, exp_q[k][0]});
                    if (bus.out_ready[k] && !m_flush) void'(exp_q[k].pop_front());
                end
            end
            check("mon_busy", {31'd0, bus.busy}, {31'd0, any});
            @(posedge clk);
            if (!rst_n) continue;
            if (m_flush) begin
                for (int k = 0; k < 5; k++) exp_q[k].delete();
            end
            exp_err = 1'b0;
            if (m_valid && rdy_exp) begin
                if (m_sel <= 3'd4) exp_q[m_sel].push_back(m_data);
                else begin
                    exp_err = 1'b1;
                    if (exp_drop < 255) exp_drop++;
                end
            end
        end
    end

    task automatic drive(input logic [DW-1:0] d, input logic [2:0] s, input logic v);
        bus.in_data  = d;
        bus.in_sel   = s;
        bus.in_valid = v;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    // Directed stimulus with hand-computed spot checks.
    initial begin
        int n;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 5'b00000;
        drive('0, 3'd0, 1'b0);
        #2;
        check("rst_valid", {27'd0, bus.out_valid}, 32'd0);
        check("rst_data0", {16'd0, bus.out_data0}, 32'd0);
        check("rst_data4", {16'd0, bus.out_data4}, 32'd0);
        check("rst_err", {31'd0, bus.err_sel}, 32'd0);
        check("rst_drop", {24'd0, bus.drop_cnt}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        next_cyc();
        rst_n = 1'b1;

        // Two lanes, consumers always ready.
        bus.out_ready = 5'b11111;
        drive(16'h1111, 3'd0, 1'b1);
        next_cyc(); drive(16'h2222, 3'd3, 1'b1); #1;
        check("t1_v0", {31'd0, bus.out_valid[0]}, 32'd1);
        check("t1_d0", {16'd0, bus.out_data0}, 32'h1111);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t1_v3", {27'd0, bus.out_valid}, 32'b01000);
        check("t1_d3", {16'd0, bus.out_data3}, 32'h2222);
        next_cyc(); #1;
        check("t1_busy", {31'd0, bus.busy}, 32'd0);

        // Lane 2 stalled: fills at two, lane 1 still flows, then drains in order.
        bus.out_ready = 5'b11011;
        drive(16'h000A, 3'd2, 1'b1);
        next_cyc(); drive(16'h000B, 3'd2, 1'b1);
        next_cyc(); drive(16'h5151, 3'd1, 1'b1); #1;
        check("t2_rdy_l1", {31'd0, bus.in_ready}, 32'd1);
        next_cyc(); drive(16'h000C, 3'd2, 1'b1); #1;
        check("t2_rdy_full", {31'd0, bus.in_ready}, 32'd0);
        check("t2_head_a", {16'd0, bus.out_data2}, 32'h000A);
        next_cyc(); bus.out_ready = 5'b11111; #1;
        check("t2_rdy_full_pop", {31'd0, bus.in_ready}, 32'd0);
        next_cyc(); #1;
        check("t2_rdy_after", {31'd0, bus.in_ready}, 32'd1);
        check("t2_head_b", {16'd0, bus.out_data2}, 32'h000B);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t2_head_c", {16'd0, bus.out_data2}, 32'h000C);
        next_cyc();

        // Lane 4 full with simultaneous pop: refused, then accepted as new head.
        bus.out_ready = 5'b01111;
        drive(16'h4001, 3'd4, 1'b1);
        next_cyc(); drive(16'h4002, 3'd4, 1'b1);
        next_cyc(); drive(16'h4003, 3'd4, 1'b1); bus.out_ready = 5'b11111; #1;
        check("t3_refuse", {31'd0, bus.in_ready}, 32'd0);
        next_cyc(); #1;
        check("t3_accept", {31'd0, bus.in_ready}, 32'd1);
        check("t3_head", {16'd0, bus.out_data4}, 32'h4002);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t3_last", {16'd0, bus.out_data4}, 32'h4003);
        check("t3_last_v", {31'd0, bus.out_valid[4]}, 32'd1);
        next_cyc();

        // Illegal destinations, back to back, then saturation.
        drive(16'hDEAD, 3'd5, 1'b1); #1;
        check("t4_rdy5", {31'd0, bus.in_ready}, 32'd1);
        next_cyc(); drive(16'hBEEF, 3'd6, 1'b1); #1;
        check("t4_err1", {31'd0, bus.err_sel}, 32'd1);
        next_cyc(); drive(16'hCAFE, 3'd7, 1'b1); #1;
        check("t4_rdy7", {31'd0, bus.in_ready}, 32'd1);
        check("t4_err2", {31'd0, bus.err_sel}, 32'd1);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t4_err3", {31'd0, bus.err_sel}, 32'd1);
        next_cyc(); #1;
        check("t4_cnt3", {24'd0, bus.drop_cnt}, 32'd3);
        check("t4_err_low", {31'd0, bus.err_sel}, 32'd0);
        check("t4_novalid", {27'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 260; i++) begin
            drive(DW'(i), 3'(5 + (i % 3)), 1'b1);
            next_cyc();
        end
        drive('0, 3'd0, 1'b0);
        next_cyc(); #1;
        check("t4_sat", {24'd0, bus.drop_cnt}, 32'd255);

        // One word per lane, then flush with a pending word and full ready.
        bus.out_ready = 5'b00000;
        for (int k = 0; k < 5; k++) begin
            drive(DW'(16'h0F00 + k), 3'(k), 1'b1);
            next_cyc();
        end
        drive(16'hF0F0, 3'd0, 1'b1);
        bus.flush = 1'b1;
        bus.out_ready = 5'b11111; #1;
        check("t5_flush_rdy", {31'd0, bus.in_ready}, 32'd0);
        check("t5_pre_valid", {27'd0, bus.out_valid}, 32'b11111);
        next_cyc(); bus.flush = 1'b0; drive('0, 3'd0, 1'b0); #1;
        check("t5_valid", {27'd0, bus.out_valid}, 32'd0);
        check("t5_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_drop", {24'd0, bus.drop_cnt}, 32'd255);

        // Asynchronous reset while lanes hold data and err_sel is high.
        bus.out_ready = 5'b00000;
        drive(16'h6000, 3'd0, 1'b1);
        next_cyc(); drive(16'h6002, 3'd2, 1'b1);
        next_cyc(); drive(16'h6666, 3'd6, 1'b1);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t6_pre_err", {31'd0, bus.err_sel}, 32'd1);
        check("t6_pre_valid", {27'd0, bus.out_valid}, 32'b00101);
        rst_n = 1'b0; #1;
        check("t6_valid", {27'd0, bus.out_valid}, 32'd0);
        check("t6_data0", {16'd0, bus.out_data0}, 32'd0);
        check("t6_data2", {16'd0, bus.out_data2}, 32'd0);
        check("t6_err", {31'd0, bus.err_sel}, 32'd0);
        check("t6_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_drop", {24'd0, bus.drop_cnt}, 32'd0);
        #2 rst_n = 1'b1;
        next_cyc(); drive(16'h7777, 3'd1, 1'b1); #1;
        check("t6_rdy", {31'd0, bus.in_ready}, 32'd1);
        next_cyc(); drive('0, 3'd0, 1'b0); #1;
        check("t6_v1", {27'd0, bus.out_valid}, 32'b00010);
        check("t6_d1", {16'd0, bus.out_data1}, 32'h7777);
        bus.out_ready = 5'b11111;

        n = 0;
        while (bus.busy && n < 20) begin
            next_cyc();
            n++;
        end
        check("drain_timeout", {31'd0, bus.busy}, 32'd0);
        next_cyc();
        for (int k = 0; k < 5; k++)
            check($sformatf("left_in_q%0d", k), exp_q[k].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
